// File: rtl/dcache_mem_responder.sv
// Fixed-latency 128-bit line memory answering the data cache's mem_read/mem_write + mem_busywait handshake.
// Optional macro DMEM_ACCESS_COUNT_EN adds read_count/write_count access counters.
module dcache_mem_responder #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [127:0]      mem_writedata,
  output logic [127:0]      mem_readdata,
  output logic              mem_busywait
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q;
  logic [127:0]     wdata_q;
  logic [127:0]     rdata_q;
  logic             op_wr_q;
  logic [127:0]     mem_q [DEPTH];

  logic req, accept, done;
  logic unused_addr_hi;

  // Upper block-address bits alias onto the array.
  assign unused_addr_hi = ^mem_address[ADDR_W-1:IDX_W];

  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) && req;
  assign done   = (state_q == BUSY) && (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 8'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_busywait = accept || (state_q == BUSY);
  assign mem_readdata = rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_address[IDX_W-1:0];
        wdata_q <= mem_writedata;
        op_wr_q <= mem_write;  // write wins when both are raised
      end
      if (done && !op_wr_q) rdata_q <= mem_q[addr_q];
    end
  end

  // Array has no reset; an access aborted by reset never reaches done.
  always_ff @(posedge clk) begin
    if (done && op_wr_q) mem_q[addr_q] <= wdata_q;
  end

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] read_cnt_q, write_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_cnt_q  <= 32'd0;
      write_cnt_q <= 32'd0;
    end else if (done) begin
      if (op_wr_q) write_cnt_q <= write_cnt_q + 32'd1;
      else         read_cnt_q  <= read_cnt_q + 32'd1;
    end
  end

  assign read_count  = read_cnt_q;
  assign write_count = write_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder (LATENCY=5, DEPTH=256); counter checks only when DMEM_ACCESS_COUNT_EN is defined.
module tb_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0]  read_count;
  logic [31:0]  write_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] KEEP  = 128'h21212121_21212121_21212121_21212121;
  localparam logic [127:0] D_ORG = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [127:0] D_NEW = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
  localparam logic [127:0] D_DRP = 128'h0BADF00D_CAFEBABE_DEADBEEF_01234567;
  localparam logic [127:0] D_RST = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

  dcache_mem_responder #(.LATENCY(5), .DEPTH(256), .ADDR_W(28)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .read_count    (read_count),
    .write_count   (write_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request at a negedge and follows it until busywait falls (the RESP cycle).
  task automatic access(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, output int nbusy, output logic [127:0] resp_data);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
    nbusy = 0;
    #1;
    for (int i = 0; i < 50 && mem_busywait; i++) begin
      nbusy++;
      @(negedge clk);
      #1;
    end
    resp_data = mem_readdata;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  int           nb;
  logic [127:0] rd;

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_writedata = '0;
    #2;
    chk("reset_busywait_idle", {127'd0, mem_busywait}, 128'd0);
    chk("reset_readdata", mem_readdata, 128'd0);
    mem_read = 1'b1; #1;
    chk("reset_busywait_req", {127'd0, mem_busywait}, 128'd1);
    mem_read = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    access(1'b0, 1'b1, 28'h10, LINE1, nb, rd);
    chk("wr10_busy_cycles", 128'(nb), 128'd6);
    chk("wr10_readdata_kept", rd, 128'd0);
    access(1'b1, 1'b0, 28'h10, '0, nb, rd);
    chk("rd10_busy_cycles", 128'(nb), 128'd6);
    chk("rd10_data", rd, LINE1);

    access(1'b1, 1'b1, 28'h3, 128'h1, nb, rd);
    chk("rdwr3_busy_cycles", 128'(nb), 128'd6);
    chk("rdwr3_readdata_kept", rd, LINE1);
    access(1'b1, 1'b0, 28'h3, '0, nb, rd);
    chk("rd3_data", rd, 128'h1);

    access(1'b0, 1'b1, 28'h105, 128'hA5, nb, rd);
    access(1'b1, 1'b0, 28'h005, '0, nb, rd);
    chk("alias_005_data", rd, 128'hA5);

    // Address/data changed two cycles after acceptance must be ignored.
    access(1'b0, 1'b1, 28'h21, KEEP, nb, rd);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 28'h20; mem_writedata = D_ORG;
    @(negedge clk); @(negedge clk);
    mem_address = 28'h21; mem_writedata = D_NEW;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!mem_busywait) break;
      @(negedge clk);
    end
    mem_write = 1'b0;
    access(1'b1, 1'b0, 28'h20, '0, nb, rd);
    chk("midbusy_line20", rd, D_ORG);
    access(1'b1, 1'b0, 28'h21, '0, nb, rd);
    chk("midbusy_line21", rd, KEEP);

    // Dropping the request during BUSY does not abort the write.
    @(negedge clk);
    mem_write = 1'b1; mem_address = 28'h30; mem_writedata = D_DRP;
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    nb = 0;
    for (int i = 0; i < 50 && mem_busywait; i++) begin
      nb++;
      @(negedge clk);
      #1;
    end
    chk("drop_req_busy_after_drop", 128'(nb), 128'd5);
    access(1'b1, 1'b0, 28'h30, '0, nb, rd);
    chk("drop_req_line30", rd, D_DRP);

    // Reset in the 3rd BUSY cycle of a write discards it.
    access(1'b0, 1'b1, 28'h40, 128'd0, nb, rd);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 28'h40; mem_writedata = D_RST;
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b0; mem_write = 1'b0;
    #1;
    chk("rst_mid_busywait", {127'd0, mem_busywait}, 128'd0);
    chk("rst_mid_readdata", mem_readdata, 128'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_release_busywait", {127'd0, mem_busywait}, 128'd0);
    access(1'b1, 1'b0, 28'h40, '0, nb, rd);
    chk("rst_mid_rd40_busy", 128'(nb), 128'd6);
    chk("rst_mid_line40", rd, 128'd0);

`ifdef DMEM_ACCESS_COUNT_EN
    // One read so far since reset; add two reads and two writes.
    access(1'b1, 1'b0, 28'h10, '0, nb, rd);
    access(1'b0, 1'b1, 28'h50, 128'h5, nb, rd);
    access(1'b1, 1'b0, 28'h50, '0, nb, rd);
    access(1'b0, 1'b1, 28'h51, 128'h6, nb, rd);
    #1;
    chk("read_count_3", 128'(read_count), 128'd3);
    chk("write_count_2", 128'(write_count), 128'd2);
    @(negedge clk);
    force dut.read_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.read_cnt_q;
    access(1'b1, 1'b0, 28'h50, '0, nb, rd);
    #1;
    chk("read_count_wrap", 128'(read_count), 128'd0);
    chk("write_count_hold", 128'(write_count), 128'd2);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_mem_responder.md
# dcache_mem_responder

Multi-cycle main-memory responder for the data cache's line-refill/write-back port. It answers the `mem_read`/`mem_write` + `mem_busywait` handshake that the data cache drives. It stores 128-bit lines and models fixed access latency with an explicit state machine. It sits below the data cache, in place of the behavioural data memory, so that cache-switch and context-switch experiments see deterministic miss penalties.

## Interface
Parameters:
- `LATENCY`, default 5: cycles spent in BUSY per access; legal range 1..255.
- `DEPTH`, default 256: number of 128-bit lines; must be a power of two.
- `ADDR_W`, default 28: width of the block address (byte address bits [31:4]).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `mem_read` in 1: line read request, level, held by the cache until the response.
- `mem_write` in 1: line write request, level, held by the cache until the response.
- `mem_address` in ADDR_W: block address; low log2(DEPTH) bits index the array, upper bits are ignored.
- `mem_writedata` in 128: line to write; word 0 is in bits [31:0].
- `mem_readdata` out 128: line returned by the last completed read.
- `mem_busywait` out 1: stall to the cache.

## Operation
- States: IDLE, BUSY, RESP.
- `req = mem_read | mem_write`.
- `mem_busywait = (state==IDLE & req) | (state==BUSY)`. It is combinational so the cache stalls in the same cycle it raises a request. It is 0 in RESP.
- IDLE, with `req` at the edge:
  - latch `addr_q` from `mem_address`, `wdata_q` from `mem_writedata` and `op_q`;
  - load `cnt` with LATENCY-1;
  - go to BUSY.
- IDLE without `req`: stay.
- Op encoding: `op_q` = write if `mem_write`, else read. Simultaneous read and write → write wins and the read is dropped; no error is flagged.
- BUSY, `cnt != 0` at the edge: `cnt` decrements.
- BUSY, `cnt == 0` at the edge, then go to RESP:
  - write: `mem[addr_q] <= wdata_q`;
  - read: `mem_readdata <= mem[addr_q]`.
- Request changes during BUSY: address and data changes are ignored because they were latched at acceptance. Dropping `req` during BUSY does not abort; the access still completes.
- RESP lasts exactly one cycle and ignores `req`, then goes to IDLE. The cache must drop or replace its request in the RESP cycle. A request still high in the following IDLE cycle starts a new access.
- `mem_readdata` holds its value until the next read completes; writes do not change it.
- The memory array is not cleared by reset. Contents are X until written.

## Timing
- Reset values (asynchronous, while `reset`=0): state=IDLE, `cnt`=0, `mem_readdata`=0, `mem_busywait`=0 unless `req` is high. In-flight accesses are discarded. A write in BUSY when reset asserts is not performed.
- Request first seen in cycle T:
  - `mem_busywait` is high in cycles T..T+LATENCY (LATENCY+1 cycles);
  - RESP is in cycle T+LATENCY+1, with `mem_busywait`=0 and read data valid on `mem_readdata`;
  - IDLE is in cycle T+LATENCY+2.
- Back-to-back throughput: one line per LATENCY+2 cycles.
- LATENCY=1: BUSY lasts a single cycle with `cnt`=0 on entry.

## Configuration
- `DMEM_ACCESS_COUNT_EN`, defined:
  - adds output ports `read_count` (32 bits) and `write_count` (32 bits);
  - each increments by 1 on the BUSY→RESP edge for its op;
  - both wrap from 0xFFFFFFFF to 0 and reset to 0.
- Not defined: the ports and counters are absent. Handshake behaviour is identical either way.

## Test plan
- Write then read, LATENCY=5:
  - stimulus: write 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA to address 0x10 held until RESP, then read 0x10;
  - required: `mem_busywait` high exactly 6 cycles per access, then `mem_readdata` equals the written line in the read's RESP cycle.
- Read and write asserted together to address 0x3, with data 0x1:
  - required: write performed, `mem_readdata` unchanged;
  - a following read of 0x3 returns 0x1.
- Address aliasing, DEPTH=256:
  - stimulus: write 0xA5 (zero-extended) to address 0x105, read address 0x005;
  - required: the read returns 0xA5.
- Mid-BUSY input changes:
  - stimulus: change `mem_address` from 0x20 to 0x21 and `mem_writedata` 2 cycles after acceptance;
  - required: line 0x20 receives the original data and line 0x21 is untouched.
- Reset mid-write:
  - stimulus: pull `reset` low in the 3rd BUSY cycle of a write to 0x40 (prior contents 0x0);
  - required: `mem_busywait` drops immediately, state is IDLE, a later read of 0x40 returns 0x0.
- With `DMEM_ACCESS_COUNT_EN`:
  - stimulus: 3 reads and 2 writes;
  - required: `read_count`=3, `write_count`=2.
  - stimulus: preload `read_count` to 0xFFFFFFFF via force, then one read;
  - required: `read_count`=0.
